message_scroller: RTL and testbench

MESSAGE_SCROLLER -- requirements
Module: message_scroller

---
 rtl/scroller_pkg.sv | 23 ++
 rtl/btn_debouncer.sv | 88 ++++++++
 rtl/message_scroller.sv | 124 ++++++++++++
 tb/tb_message_scroller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/scroller_pkg.sv
// Shared constants and types for the message scroller: character geometry,
// power-up message and debouncer state encoding.
package scroller_pkg;

   localparam int CHAR_W  = 4;
   localparam int MSG_LEN = 16;
   localparam int PTR_W   = 4;

   // Slot i holds character i, so the reset window reads 0123.
   localparam logic [CHAR_W*MSG_LEN-1:0] RESET_MSG = 64'hFEDC_BA98_7654_3210;

   typedef enum logic [1:0] {
      DB_IDLE         = 2'd0,
      DB_WAIT_PRESS   = 2'd1,
      DB_PRESSED      = 2'd2,
      DB_WAIT_RELEASE = 2'd3
   } db_state_t;

   function automatic logic [CHAR_W-1:0] reset_char(input int idx);
      return RESET_MSG[idx*CHAR_W +: CHAR_W];
   endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus press/release debouncer; emits one press_pulse
// per accepted press, however long the button is held.
module btn_debouncer
   import scroller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press_pulse
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam bit              SINGLE   = (DEBOUNCE_CYCLES <= 1);

   logic [1:0]       sync_r;
   db_state_t        state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             pulse_r;
   logic             btn_s;

   assign btn_s       = sync_r[1];
   assign press_pulse = pulse_r;

   // Synchroniser, debounce FSM and registered press pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_r  <= 2'b00;
         state_r <= DB_IDLE;
         cnt_r   <= CNT_ZERO;
         pulse_r <= 1'b0;
      end else begin
         sync_r  <= {sync_r[0], btn_raw};
         pulse_r <= 1'b0;
         case (state_r)
            DB_IDLE: begin
               if (btn_s && SINGLE) begin
                  state_r <= DB_PRESSED;
                  pulse_r <= 1'b1;
               end else if (btn_s) begin
                  state_r <= DB_WAIT_PRESS;
                  cnt_r   <= CNT_ONE;
               end
            end
            DB_WAIT_PRESS: begin
               if (!btn_s) begin
                  state_r <= DB_IDLE;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_r <= DB_PRESSED;
                  cnt_r   <= CNT_ZERO;
                  pulse_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            DB_PRESSED: begin
               if (!btn_s && SINGLE) begin
                  state_r <= DB_IDLE;
               end else if (!btn_s) begin
                  state_r <= DB_WAIT_RELEASE;
                  cnt_r   <= CNT_ONE;
               end
            end
            DB_WAIT_RELEASE: begin
               if (btn_s) begin
                  state_r <= DB_PRESSED;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_r <= DB_IDLE;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r <= DB_IDLE;
               cnt_r   <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: rtl/message_scroller.sv
// 16-character circular message shown through a 4-character window, stepped by
// a timer or a debounced button. Define SCROLL_REVERSE_EN to add the dir input.
module message_scroller
   import scroller_pkg::*;
#(
   parameter int STEP_DIV        = 12_500_000,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btn,
   input  logic                auto_en,
`ifdef SCROLL_REVERSE_EN
   input  logic                dir,
`endif
   input  logic                wr_en,
   input  logic [PTR_W-1:0]    wr_addr,
   input  logic [CHAR_W-1:0]   wr_data,
   output logic [4*CHAR_W-1:0] digits,
   output logic                step
);

   localparam int              TICK_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};

   logic [CHAR_W-1:0]   mem_r      [MSG_LEN];
   logic [CHAR_W-1:0]   mem_next_s [MSG_LEN];
   logic [PTR_W-1:0]    pos_r;
   logic [PTR_W-1:0]    pos_next_s;
   logic [TICK_W-1:0]   tick_r;
   logic [TICK_W-1:0]   tick_next_s;
   logic                auto_en_r;
   logic                step_s;
   logic                step_r;
   logic                dir_s;
   logic                press_pulse_s;
   logic [4*CHAR_W-1:0] digits_r;
   logic [4*CHAR_W-1:0] digits_next_s;

`ifdef SCROLL_REVERSE_EN
   assign dir_s = dir;
`else
   assign dir_s = 1'b0;
`endif

   btn_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn),
      .press_pulse (press_pulse_s)
   );

   // Step source selection; a mode change restarts the tick counter silently.
   always_comb begin
      step_s      = 1'b0;
      tick_next_s = TICK_ZERO;
      if (auto_en != auto_en_r) begin
         step_s      = 1'b0;
         tick_next_s = TICK_ZERO;
      end else if (auto_en) begin
         if (tick_r == TICK_LAST) begin
            step_s      = 1'b1;
            tick_next_s = TICK_ZERO;
         end else begin
            step_s      = 1'b0;
            tick_next_s = tick_r + TICK_W'(1);
         end
      end else begin
         step_s      = press_pulse_s;
         tick_next_s = TICK_ZERO;
      end
   end

   // Next pointer, write-forwarded buffer view and the resulting window.
   always_comb begin
      pos_next_s = pos_r;
      if (!step_s) begin
         pos_next_s = pos_r;
      end else if (dir_s) begin
         pos_next_s = pos_r - 4'd1;
      end else begin
         pos_next_s = pos_r + 4'd1;
      end
      for (int i = 0; i < MSG_LEN; i++) begin
         if (wr_en && (wr_addr == PTR_W'(i))) begin
            mem_next_s[i] = wr_data;
         end else begin
            mem_next_s[i] = mem_r[i];
         end
      end
      digits_next_s = {mem_next_s[pos_next_s],         mem_next_s[pos_next_s + 4'd1],
                       mem_next_s[pos_next_s + 4'd2],  mem_next_s[pos_next_s + 4'd3]};
   end

   // Buffer, pointer, tick counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < MSG_LEN; i++) begin
            mem_r[i] <= reset_char(i);
         end
         pos_r     <= 4'd0;
         tick_r    <= TICK_ZERO;
         auto_en_r <= auto_en;
         step_r    <= 1'b0;
         digits_r  <= 16'h0123;
      end else begin
         for (int i = 0; i < MSG_LEN; i++) begin
            mem_r[i] <= mem_next_s[i];
         end
         pos_r     <= pos_next_s;
         tick_r    <= tick_next_s;
         auto_en_r <= auto_en;
         step_r    <= step_s;
         digits_r  <= digits_next_s;
      end
   end

   assign digits = digits_r;
   assign step   = step_r;

endmodule

// File: tb/tb_message_scroller.sv
// Scoreboard bench for message_scroller with STEP_DIV=4, DEBOUNCE_CYCLES=3.
// Define SCROLL_REVERSE_EN to also exercise reverse stepping.
module tb_message_scroller;

   logic        clk = 1'b0;
   logic        reset;
   logic        btn;
   logic        auto_en;
   logic        dir;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [3:0]  wr_data;
   logic [15:0] digits;
   logic        step;

   int checks     = 0;
   int errors     = 0;
   int exp_steps  = 0;
   int seen_steps = 0;

   logic [15:0] sb [$];
   logic [3:0]  m  [16];
   int          p;

   always #5 clk = ~clk;

   message_scroller #(
      .STEP_DIV        (4),
      .DEBOUNCE_CYCLES (3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .btn     (btn),
      .auto_en (auto_en),
`ifdef SCROLL_REVERSE_EN
      .dir     (dir),
`endif
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .digits  (digits),
      .step    (step)
   );

   function automatic logic [15:0] win(input int q);
      return {m[q % 16], m[(q + 1) % 16], m[(q + 2) % 16], m[(q + 3) % 16]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m[i] = 4'(i);
      p = 0;
   endtask

   task automatic expect_step(input bit rev);
      p = rev ? (p + 15) % 16 : (p + 1) % 16;
      exp_steps++;
      sb.push_back(win(p));
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_count(input string name);
      checks++;
      if (seen_steps != exp_steps) begin
         errors++;
         $display("FAIL %s: steps seen %0d expected %0d", name, seen_steps, exp_steps);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int hold);
      btn = 1'b1;
      cycles(hold);
      btn = 1'b0;
      cycles(12);
   endtask

   // Monitor: every step pulse must match the oldest expected window.
   always @(negedge clk) begin
      if (reset === 1'b1 && step === 1'b1) begin
         seen_steps++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_step: got digits %h with nothing expected", digits);
         end else begin
            logic [15:0] e;
            e = sb.pop_front();
            if (digits !== e) begin
               errors++;
               $display("FAIL step_window: got %h expected %h", digits, e);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; btn = 1'b0; auto_en = 1'b1; dir = 1'b0;
      wr_en = 1'b0; wr_addr = 4'd0; wr_data = 4'd0;
      model_reset();
      cycles(3);
      @(negedge clk);
      chk("reset_digits", digits, 16'h0123);
      chk("reset_step", {15'd0, step}, 16'd0);

      // Timed scrolling: first step four cycles after release, then 28 more.
      @(posedge clk); #1;
      reset = 1'b1;
      expect_step(1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("auto_latency_early", {15'd0, step}, 16'd0);
      @(posedge clk);
      @(negedge clk);
      chk("auto_latency_first", {15'd0, step}, 16'd1);
      for (int k = 1; k < 29; k++) begin
         expect_step(1'b0);
         repeat (4) @(posedge clk);
      end
      #1;
      auto_en = 1'b0;
      cycles(10);
      chk_count("auto_stop");
      chk("pos13_window", digits, 16'hDEF0);

      // Button scrolling: long hold, short glitch, bounce.
      expect_step(1'b0);
      press(10);
      chk_count("btn_long_hold");
      press(2);
      chk_count("btn_short_pulse");
      btn = 1'b1; cycles(1);
      btn = 1'b0; cycles(1);
      btn = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk_count("btn_bounce_early");
      expect_step(1'b0);
      cycles(10);
      btn = 1'b0;
      cycles(12);
      chk_count("btn_bounce_settled");

      // Back to pos 0, then a write landing in the same cycle as a step.
      expect_step(1'b0);
      press(8);
      chk("pos0_window", digits, 16'h0123);
      auto_en = 1'b1;
      cycles(4);
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'hA;
      m[2] = 4'hA;
      expect_step(1'b0);
      cycles(1);
      wr_en = 1'b0; auto_en = 1'b0;
      @(negedge clk);
      chk("write_with_step", digits, 16'h1A34);
      cycles(1);
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'hB;
      m[3] = 4'hB;
      cycles(1);
      wr_en = 1'b0;
      @(negedge clk);
      chk("write_visible", digits, 16'h1AB4);
      cycles(1);
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 4'h5;
      m[9] = 4'h5;
      cycles(1);
      wr_en = 1'b0;
      @(negedge clk);
      chk("write_hidden", digits, 16'h1AB4);
      cycles(6);
      chk_count("write_phase");

      // Mode flip mid-count must not step.
      auto_en = 1'b1;
      cycles(3);
      auto_en = 1'b0;
      cycles(8);
      chk_count("mode_flip");

      // Reset while the debouncer waits on a press abandons it.
      btn = 1'b1;
      cycles(4);
      reset = 1'b0; btn = 1'b0;
      cycles(2);
      reset = 1'b1;
      model_reset();
      cycles(15);
      chk_count("reset_mid_debounce");
      chk("post_reset_digits", digits, 16'h0123);

`ifdef SCROLL_REVERSE_EN
      dir = 1'b1;
      expect_step(1'b1);
      press(8);
      chk("reverse_window", digits, 16'hF012);
      dir = 1'b0;
`endif

      cycles(5);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected steps never seen", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
